// File: rtl/obstacle_blitter_if.sv
// obstacle_blitter_if
//   Blit command channel from the obstacle blitter to the sprite/framebuffer
//   writer. One command per visible obstacle, transferred on a valid/ready
//   handshake; a command moves when cmd_valid and cmd_ready are both high at a
//   rising clock edge.
//
//   cmd_valid  master->slave  command fields below are meaningful
//   cmd_ready  slave->master  writer accepts the current command
//   cmd_x      master->slave  clipped screen x
//   cmd_y      master->slave  screen y
//   cmd_w      master->slave  clipped width (always >= 1)
//   cmd_h      master->slave  height
//   cmd_src_x  master->slave  first sprite column to draw (left-clip amount)
//   cmd_slot   master->slave  obstacle slot the command came from
//   cmd_frame  master->slave  sprite animation frame
interface obstacle_blitter_if #(
  parameter int FRAME_W = 2
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [9:0]         cmd_x;
  logic [9:0]         cmd_y;
  logic [9:0]         cmd_w;
  logic [9:0]         cmd_h;
  logic [9:0]         cmd_src_x;
  logic [2:0]         cmd_slot;
  logic [FRAME_W-1:0] cmd_frame;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_src_x, cmd_slot, cmd_frame,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_src_x, cmd_slot, cmd_frame,
    output cmd_ready
  );
endinterface

// File: rtl/obstacle_blitter.sv
// obstacle_blitter
//   Consumer side of the horizon obstacle queue. On frame_start it snapshots
//   every obstacle slot, then walks the slots in queue order starting at the
//   front index (wrapping), and for each visible obstacle emits one blit
//   command, clipped to the visible screen width, to the pixel writer.
//
//   clk          system clock
//   rst          synchronous reset, active low
//   frame_start  one-cycle pulse that begins a blit pass
//   front        oldest queue slot; values >= SLOTS start the scan at slot 0
//   obj_start    per-slot occupied flag
//   obj_x        per-slot signed left x (11 bits)
//   obj_y        per-slot top y
//   obj_w        per-slot width (0 = nothing to draw)
//   obj_h        per-slot height
//   obj_frame    per-slot animation frame
//   cmd          blit command channel (master side)
//   busy         a pass is in progress
//   done         one-cycle pulse at the end of a pass
//   drawn        number of commands issued in the last completed pass
//   overrun      one-cycle pulse when frame_start arrives during a pass
module obstacle_blitter #(
  parameter int SLOTS      = 7,
  parameter int GAME_WIDTH = 640,
  parameter int FRAME_W    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic [2:0]                      front,
  input  logic [SLOTS-1:0]                obj_start,
  input  logic [SLOTS-1:0][10:0]          obj_x,
  input  logic [SLOTS-1:0][9:0]           obj_y,
  input  logic [SLOTS-1:0][9:0]           obj_w,
  input  logic [SLOTS-1:0][9:0]           obj_h,
  input  logic [SLOTS-1:0][FRAME_W-1:0]   obj_frame,
  obstacle_blitter_if.master              cmd,
  output logic                            busy,
  output logic                            done,
  output logic [2:0]                      drawn,
  output logic                            overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic signed [11:0] GW       = 12'(GAME_WIDTH);
  localparam logic [2:0]         LAST_IDX = 3'(SLOTS - 1);

  state_t state;

  // Frozen copy of the obstacle table for the duration of a pass.
  logic [SLOTS-1:0]              snap_start;
  logic [SLOTS-1:0][10:0]        snap_x;
  logic [SLOTS-1:0][9:0]         snap_y;
  logic [SLOTS-1:0][9:0]         snap_w;
  logic [SLOTS-1:0][9:0]         snap_h;
  logic [SLOTS-1:0][FRAME_W-1:0] snap_frame;

  logic [2:0] idx;
  logic [2:0] n;
  logic [2:0] cnt;

  logic signed [11:0] cur_x;
  logic signed [11:0] cur_w;
  logic signed [11:0] cur_r;
  logic signed [11:0] vis_x;
  logic               left_clip;
  logic               drawable;
  logic [9:0]         x_out;
  logic [9:0]         w_out;
  logic [9:0]         src_out;
  logic [2:0]         idx_next;
  logic               last_slot;

  // Visibility test and clipping for the slot currently under the scan
  // pointer. Everything is done in 12-bit signed arithmetic so that the
  // right edge x+w of a far-left or far-right sprite cannot wrap. A sprite
  // hanging off both edges gets both clips; the left clip moves the start
  // column into the sprite, the right clip trims the width to the screen.
  always_comb begin
    cur_x     = {snap_x[idx][10], snap_x[idx]};
    cur_w     = {2'b00, snap_w[idx]};
    cur_r     = cur_x + cur_w;
    left_clip = cur_x[11];
    vis_x     = left_clip ? 12'sd0 : cur_x;
    drawable  = snap_start[idx] && (snap_w[idx] != 10'd0) && (cur_x < GW) && (cur_r > 12'sd0);
    x_out     = 10'(vis_x);
    src_out   = left_clip ? 10'(-cur_x) : 10'd0;
    w_out     = left_clip ? 10'(cur_r) : 10'(cur_w);
    if (cur_r > GW) begin
      w_out = 10'(GW - vis_x);
    end
    idx_next  = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    last_slot = (n == LAST_IDX);
  end

  // Pass sequencer. Exactly SLOTS slots are visited per pass, one SCAN cycle
  // each; a visible slot detours through EMIT until the writer takes the
  // command, so there is always a SCAN cycle between two commands. The done
  // pulse and the drawn update are issued from the DONE state itself, which
  // makes them appear one cycle after the last slot has been handled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= 3'd0;
      n             <= 3'd0;
      cnt           <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      drawn         <= 3'd0;
      overrun       <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_x     <= 10'd0;
      cmd.cmd_y     <= 10'd0;
      cmd.cmd_w     <= 10'd0;
      cmd.cmd_h     <= 10'd0;
      cmd.cmd_src_x <= 10'd0;
      cmd.cmd_slot  <= 3'd0;
      cmd.cmd_frame <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= frame_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap_start <= obj_start;
            snap_x     <= obj_x;
            snap_y     <= obj_y;
            snap_w     <= obj_w;
            snap_h     <= obj_h;
            snap_frame <= obj_frame;
            idx        <= (front >= 3'(SLOTS)) ? 3'd0 : front;
            n          <= 3'd0;
            cnt        <= 3'd0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (drawable) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_x     <= x_out;
            cmd.cmd_y     <= snap_y[idx];
            cmd.cmd_w     <= w_out;
            cmd.cmd_h     <= snap_h[idx];
            cmd.cmd_src_x <= src_out;
            cmd.cmd_slot  <= idx;
            cmd.cmd_frame <= snap_frame[idx];
            state         <= EMIT;
          end else if (last_slot) begin
            state <= DONE;
          end else begin
            idx <= idx_next;
            n   <= n + 3'd1;
          end
        end
        EMIT: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            cnt           <= cnt + 3'd1;
            if (last_slot) begin
              state <= DONE;
            end else begin
              idx   <= idx_next;
              n     <= n + 3'd1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          drawn <= cnt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
